// File: rtl/bram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for the shared block-RAM port arbiter.
// slave = arbiter side, master = requesters plus the RAM instance.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16
) ();
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         mem_addra;
  logic [DATA_W-1:0]         mem_dina;
  logic                      mem_wea;
  logic [DATA_W-1:0]         mem_douta;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_douta,
    output req_ready, rsp_valid, rsp_data, mem_addra, mem_dina, mem_wea
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_douta,
    input  req_ready, rsp_valid, rsp_data, mem_addra, mem_dina, mem_wea
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one block-RAM port between NUM_REQ requesters, one access per clock.
// Read tags ride a RD_LAT-deep pipe alongside the RAM latency so data returns to its issuer.
module bram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input logic                clk,
  input logic                rst,
  bram_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win;
  logic               found;
  logic [RD_LAT-1:0]  pv_q, pv_d;
  logic [PTR_W-1:0]   ptag_q [RD_LAT];
  logic [PTR_W-1:0]   ptag_d [RD_LAT];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  // First valid requester at or after rr_ptr wins; nothing is granted while in reset.
  always_comb begin : arbitrate
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    if (rst) begin
      found = 1'b0;
    end
  end

  always_comb begin : ram_drive
    bus.req_ready = '0;
    bus.mem_wea   = 1'b0;
    bus.mem_addra = '0;
    bus.mem_dina  = '0;
    if (found) begin
      bus.req_ready[win] = 1'b1;
      bus.mem_wea        = bus.req_we[win];
      bus.mem_addra      = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
      bus.mem_dina       = bus.req_wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

  always_comb begin : next_state
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end

    pv_d      = '0;
    ptag_d    = '{default: '0};
    pv_d[0]   = found & ~bus.req_we[win];
    ptag_d[0] = win;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i]   = pv_q[i-1];
      ptag_d[i] = ptag_q[i-1];
    end

    // Pipe output lines up with RAM douta for the read that launched it.
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pv_q[RD_LAT-1]) begin
      rsp_valid_d[ptag_q[RD_LAT-1]] = 1'b1;
      rsp_data_d                    = bus.mem_douta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      pv_q        <= '0;
      ptag_q      <= '{default: '0};
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pv_q        <= pv_d;
      ptag_q      <= ptag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural RAM, directed scenarios, then randomized traffic
// compared cycle by cycle against a queue-based reference of grants and read responses.
module tb_bram_port_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int RD_LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Read-first block RAM with RD_LAT clocks of read latency.
  logic [DATA_W-1:0] ram [64];
  logic [DATA_W-1:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.mem_wea) ram[bus.mem_addra] <= bus.mem_dina;
    ram_pipe[0] <= ram[bus.mem_addra];
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.mem_douta = ram_pipe[RD_LAT-1];

  typedef struct { int due; int idx; logic [DATA_W-1:0] data; bit known; } exp_t;
  typedef struct { int cyc; int idx; logic [DATA_W-1:0] data; } cap_t;

  exp_t exp_q[$];
  cap_t cap_q[$];

  logic [NUM_REQ-1:0] rv, rwe;
  logic [ADDR_W-1:0]  raddr  [NUM_REQ];
  logic [DATA_W-1:0]  rwdata [NUM_REQ];
  logic [DATA_W-1:0]  ref_mem   [64];
  bit                 ref_known [64];
  logic [DATA_W-1:0]  last_data;
  bit                 last_known;
  int m_ptr, cyc, n_checks, n_errors, obs_grant, mode, c0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) oh_idx = i;
  endfunction

  task automatic drive();
    bus.req_valid = rv;
    bus.req_we    = rwe;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]  = raddr[i];
      bus.req_wdata[i*DATA_W +: DATA_W] = rwdata[i];
    end
  endtask

  task automatic new_req(input int i);
    rv[i]     = 1'b1;
    rwe[i]    = ($urandom_range(0, 2) == 0);
    raddr[i]  = ADDR_W'($urandom_range(0, 7));
    rwdata[i] = DATA_W'($urandom);
  endtask

  // One clock: check outputs mid-cycle, then advance the reference on the edge.
  task automatic step();
    int g;
    exp_t e;
    logic [NUM_REQ-1:0] exp_oh;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && rv[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    end
    exp_oh = '0;
    if (g >= 0) exp_oh[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_oh));
    chk("mem_wea",   64'(bus.mem_wea),   (g >= 0) ? 64'(rwe[g])    : 64'd0);
    chk("mem_addra", 64'(bus.mem_addra), (g >= 0) ? 64'(raddr[g])  : 64'd0);
    chk("mem_dina",  64'(bus.mem_dina),  (g >= 0) ? 64'(rwdata[g]) : 64'd0);

    exp_oh = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      exp_oh[e.idx] = 1'b1;
      last_data  = e.data;
      last_known = e.known;
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_oh));
    if (last_known) chk("rsp_data", 64'(bus.rsp_data), 64'(last_data));

    obs_grant = oh_idx(bus.req_ready);
    if (bus.rsp_valid != '0) cap_q.push_back('{cyc, oh_idx(bus.rsp_valid), bus.rsp_data});

    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_ptr      = 0;
      last_data  = '0;
      last_known = 1'b1;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NUM_REQ;
      if (rwe[g]) begin
        ref_mem[raddr[g]]   = rwdata[g];
        ref_known[raddr[g]] = 1'b1;
      end else begin
        exp_q.push_back('{cyc + RD_LAT + 1, g, ref_mem[raddr[g]], ref_known[raddr[g]]});
      end
    end
    cyc++;
    #1;
    if (g >= 0) begin
      if (mode == 0) rv[g] = 1'b0;
      else if (mode == 2) new_req(g);
    end
    if (mode == 2) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0) new_req(i);
    end
    drive();
  endtask

  task automatic do_reset();
    rv  = '0;
    rwe = '0;
    drive();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    mode = 0;
    rv   = '0;
    drive();
    repeat (RD_LAT + 3) step();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; m_ptr = 0; mode = 0;
    last_data = '0; last_known = 1'b1;
    rv = '0; rwe = '0;
    for (int i = 0; i < NUM_REQ; i++) begin raddr[i] = '0; rwdata[i] = '0; end
    drive();
    @(posedge clk);
    #1;

    // Reset held with every requester asking.
    rv = '1;
    drive();
    repeat (3) step();
    rst = 1'b0;
    rv  = '0;
    drive();

    // Two writes then crossed reads.
    rwe[0] = 1'b1; raddr[0] = 6'h02; rwdata[0] = 16'h3f80; rv[0] = 1'b1;
    rwe[1] = 1'b1; raddr[1] = 6'h03; rwdata[1] = 16'h4208; rv[1] = 1'b1;
    drive();
    step();
    step();
    cap_q.delete();
    rwe[0] = 1'b0; raddr[0] = 6'h03; rv[0] = 1'b1;
    rwe[1] = 1'b0; raddr[1] = 6'h02; rv[1] = 1'b1;
    drive();
    c0 = cyc;
    repeat (6) step();
    chk("t2_count", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() >= 2) begin
      chk("t2_idx0",  64'(cap_q[0].idx),  64'd0);
      chk("t2_data0", 64'(cap_q[0].data), 64'h4208);
      chk("t2_lat0",  64'(cap_q[0].cyc - c0), 64'(RD_LAT + 1));
      chk("t2_idx1",  64'(cap_q[1].idx),  64'd1);
      chk("t2_data1", 64'(cap_q[1].data), 64'h3f80);
      chk("t2_lat1",  64'(cap_q[1].cyc - (c0 + 1)), 64'(RD_LAT + 1));
    end

    // Fairness with all requesters reading continuously.
    do_reset();
    mode = 1;
    rv   = '1;
    rwe  = '0;
    for (int i = 0; i < NUM_REQ; i++) raddr[i] = ADDR_W'(i);
    drive();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t3_grant", 64'(obs_grant), 64'(k % NUM_REQ));
    end
    drain();

    // Skip idle requesters: park pointer at 2 via one grant to req1.
    do_reset();
    rv[1] = 1'b1; raddr[1] = 6'h05;
    drive();
    step();
    mode  = 1;
    rv[1] = 1'b1;
    rv[3] = 1'b1; raddr[3] = 6'h06;
    drive();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_grant", 64'(obs_grant), (k % 2 == 0) ? 64'd3 : 64'd1);
    end
    drain();

    // Preload 00..03 then four back-to-back reads from different requesters.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = ADDR_W'(i); rwdata[0] = DATA_W'(16'h0010 + i);
      drive();
      step();
    end
    cap_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      rv[i] = 1'b1; rwe[i] = 1'b0; raddr[i] = ADDR_W'(i);
    end
    drive();
    repeat (8) step();
    chk("t5_count", 64'(cap_q.size()), 64'd4);
    for (int k = 0; k < cap_q.size() && k < 4; k++) begin
      chk("t5_idx",    64'(cap_q[k].idx), 64'((k + 1) % NUM_REQ));
      chk("t5_data",   64'(cap_q[k].data), 64'(16'h0010 + cap_q[k].idx));
      chk("t5_consec", 64'(cap_q[k].cyc - cap_q[0].cyc), 64'(k));
    end

    // Reset pulsed right after a read is accepted.
    do_reset();
    rv[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = 6'h00;
    drive();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cap_q.delete();
    repeat (RD_LAT + 3) step();
    chk("t6_no_rsp", 64'(cap_q.size()), 64'd0);
    rv  = '1;
    rwe = '0;
    drive();
    step();
    chk("t6_ptr", 64'(obs_grant), 64'd0);
    drain();

    // Randomized traffic with occasional mid-burst resets.
    do_reset();
    mode = 2;
    repeat (3000) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
